ram_dp_be: RTL

- Simple dual-port RAM (one write port, one read port) on a single clock. Successor to the single-port memory block.
- Read and write proceed in the same cycle, with per-lane byte enables, selectable read latency and a defined read-during-write result.
- Has a built-in clear sequencer that zeroes the array one word per cycle, replacing the all-entries-at-once reset loop.
- Used as general scratch/buffer storage by datapath blocks.

---
 rtl/ram_dp_be_pkg.sv | 16 +
 rtl/ram_rd_pipe.sv | 40 ++++
 rtl/ram_dp_be.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ram_dp_be_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its read pipeline.
package ram_dp_be_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int calc_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result register chain: Rd_latency stages of data/valid. Data only advances with
// its valid bit, so the output word holds while no result is presented.
module ram_rd_pipe #(
    parameter int Data_width = 32,
    parameter int Rd_latency = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [Data_width-1:0] in_data,
    output logic                  rd_valid,
    output logic [Data_width-1:0] rd_data
);

    logic [Rd_latency-1:0]                 valid_r;
    logic [Rd_latency-1:0][Data_width-1:0] data_r;

    // Shift valid every cycle; capture data only on a valid slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
            end
            for (int i = 1; i < Rd_latency; i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    assign rd_valid = valid_r[Rd_latency-1];
    assign rd_data  = data_r[Rd_latency-1];

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-lane byte enables, 1/2-cycle read latency, selectable
// read-during-write behaviour and a one-word-per-cycle clear sequencer.
module ram_dp_be
    import ram_dp_be_pkg::*;
#(
    parameter int Addr_width = 10,
    parameter int Data_width = 32,
    parameter int Lane_width = 8,
    parameter int Depth      = 1024,
    parameter int Rd_latency = 1,
    parameter int Rdw_mode   = RDW_OLD
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           clr_req,
    output logic                                           busy,
    input  logic                                           wr_en,
    input  logic [Addr_width-1:0]                          wr_addr,
    input  logic [Data_width-1:0]                          wr_data,
    input  logic [calc_lanes(Data_width, Lane_width)-1:0]  wr_be,
    input  logic                                           rd_en,
    input  logic [Addr_width-1:0]                          rd_addr,
    output logic [Data_width-1:0]                          rd_data,
    output logic                                           rd_valid
);

    localparam int                  Lanes     = calc_lanes(Data_width, Lane_width);
    localparam logic [Addr_width:0] DEPTH_W   = (Addr_width + 1)'(Depth);
    localparam logic [Addr_width-1:0] LAST_ADDR = Addr_width'(Depth - 1);

    logic [Data_width-1:0] mem [Depth];

    clr_state_t            state_r;
    logic [Addr_width-1:0] cnt_r;
    logic                  busy_r;

    logic                  wr_hit_s;
    logic                  rd_accept_s;
    logic                  rd_in_range_s;
    logic [Data_width-1:0] wr_old_s;
    logic [Data_width-1:0] wr_merged_s;
    logic [Data_width-1:0] rd_word_s;

    // Write qualification, lane merge and read-side word selection.
    always_comb begin
        wr_hit_s      = 1'b0;
        rd_accept_s   = 1'b0;
        rd_in_range_s = 1'b0;
        wr_old_s      = mem[wr_addr];
        wr_merged_s   = wr_old_s;
        rd_word_s     = '0;

        wr_hit_s      = wr_en && (state_r == IDLE) && ({1'b0, wr_addr} < DEPTH_W);
        rd_accept_s   = rd_en && (state_r == IDLE);
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);

        for (int k = 0; k < Lanes; k++) begin
            if (wr_be[k]) begin
                wr_merged_s[k*Lane_width +: Lane_width] = wr_data[k*Lane_width +: Lane_width];
            end else begin
                wr_merged_s[k*Lane_width +: Lane_width] = wr_old_s[k*Lane_width +: Lane_width];
            end
        end

        // Same-address write-through forwards the merged word; it equals old mem plus new lanes.
        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if ((Rdw_mode == RDW_NEW) && wr_hit_s && (wr_addr == rd_addr)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem[rd_addr];
        end
    end

    // Storage array: clear sweep has priority since user writes are locked out while busy.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem[cnt_r] <= '0;
        end else if (wr_hit_s) begin
            mem[wr_addr] <= wr_merged_s;
        end
    end

    // Clear sequencer: one word per cycle from address 0 up to Depth-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clr_req) begin
                        state_r <= CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_r == LAST_ADDR) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + Addr_width'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;

    ram_rd_pipe #(
        .Data_width (Data_width),
        .Rd_latency (Rd_latency)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_accept_s),
        .in_data  (rd_word_s),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

endmodule
